instruction_fetch: RTL
======================

# instruction_fetch

Multi-cycle-tolerant instruction fetch stage sitting directly upstream of the single-cycle control unit. Holds the PC, fetches one instruction word per instruction through a variable-latency ready handshake, and presents the latched instruction fields (op, rs, rt, rd, imm) for exactly one execute cycle. At the end of that cycle it samples the control unit's PCWre/PCSrc to advance, branch or halt.

## Interface
- PC_RESET, 32'h0000_0000, PC value after reset; bits [1:0] are forced to 0
- TIMEOUT_CYCLES, 255, maximum wait for ins_ready; used only with FETCH_TIMEOUT_EN
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- PCWre  in  1  from control unit; 1 = advance PC, 0 = halt; sampled only in EXEC
- PCSrc  in  1  from control unit; 1 = take branch target; sampled only in EXEC
- imm_ext  in  32  sign/zero-extended immediate from extender
- ins_req  out  1  instruction memory read request
- ins_addr  out  32  word-aligned read address (= PC)
- ins_ready  in  1  memory has ins_rdata valid this cycle
- ins_rdata  in  32  instruction word
- ins_valid  out  1  high for exactly the EXEC cycle
- op  out  6  IR[31:26]
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- imm16  out  16  IR[15:0]
- pc, pc_plus4  out  32  PC of the instruction in IR, and PC+4
- halted  out  1  high in HALT
- fetch_err  out  1  fetch timeout flag (FETCH_TIMEOUT_EN only)

## Operation
- States: FETCH, EXEC, HALT.
- FETCH: ins_req=1, ins_addr=PC. On an edge with ins_ready=1: IR <= ins_rdata, go to EXEC. Otherwise stay; ins_addr held stable.
- EXEC: ins_valid=1, IR stable. At the closing edge:
  - PCWre=0 -> HALT, PC unchanged.
  - PCWre=1, PCSrc=0 -> PC <= PC+4, go to FETCH.
  - PCWre=1, PCSrc=1 -> PC <= PC+4+(imm_ext<<2), go to FETCH.
  - IR <= 32'hFC00_0000 (halt opcode), so the control unit deasserts RegWre/DataMemRW while no instruction is valid.
- HALT: ins_req=0, ins_valid=0, halted=1. Only Reset exits.
- Arithmetic: 32-bit modulo 2^32. PC wraps from 32'hFFFF_FFFC to 0 without a flag. Branch offsets are signed through imm_ext.
- ins_ready is ignored outside FETCH. ins_rdata is captured only on FETCH with ins_ready=1.

## Timing
- Reset asserted, taking effect immediately:
  - state=FETCH, PC=PC_RESET, IR=32'hFC00_0000
  - ins_req=0, ins_valid=0, halted=0, fetch_err=0
- ins_req is gated low while Reset=1. The first cycle after deassert presents ins_req=1, ins_addr=PC_RESET.
- Reset during FETCH or EXEC aborts the operation. The memory must tolerate a request dropped without ready.
- Latency:
  - ins_ready in the first FETCH cycle gives 2 cycles per instruction (FETCH, EXEC).
  - Each extra wait cycle adds 1.
- pc and pc_plus4 are registered and stable throughout EXEC. ins_addr equals the new PC on the first FETCH cycle.
- PCWre/PCSrc glitches outside EXEC have no effect.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering FETCH and increments on each FETCH cycle with ins_ready=0.
  - When it reaches TIMEOUT_CYCLES with ins_ready still 0, the next edge goes to HALT and sets fetch_err=1, sticky until Reset.
  - ins_ready=1 on the same cycle the count hits the limit wins: the instruction is accepted.
- Undefined: no counter; FETCH waits indefinitely; fetch_err is tied to 0.

## Test plan
- Reset with PC_RESET=32'h0000_0010, ready always 1 -> ins_addr sequence 0x10, 0x14, 0x18; ins_valid alternates 0,1; 2 cycles/instruction.
- ins_ready delayed 3 cycles -> ins_req and ins_addr held stable 4 cycles; ins_valid exactly 1 cycle; IR = ins_rdata.
- EXEC at PC=0x20 with PCSrc=1, imm_ext=32'hFFFF_FFFE -> next ins_addr=0x1C. With imm_ext=3 -> 0x30.
- EXEC with PCWre=0 -> halted=1, ins_req=0 forever; op stays 6'b111111; Reset restores FETCH at PC_RESET.
- Reset asserted mid-FETCH (ready not yet given) -> ins_req drops in the same cycle; PC=PC_RESET; a late ins_ready is ignored.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted -> HALT with fetch_err=1 after 4 FETCH cycles. Rerun with ready on the 4th cycle -> accepted, fetch_err=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC/IR holder with a variable-latency ready handshake (FETCH -> EXEC -> FETCH/HALT).
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
  parameter logic [31:0] PC_RESET       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        PCSrc,
  input  logic [31:0] imm_ext,
  output logic        ins_req,
  output logic [31:0] ins_addr,
  input  logic        ins_ready,
  input  logic [31:0] ins_rdata,
  output logic        ins_valid,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;

  localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};
  localparam logic [31:0] IR_HALT = 32'hFC00_0000;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      FETCH: begin
        if (ins_ready) begin
          ir_d    = ins_rdata;
          state_d = EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        // The last waiting cycle ends the fetch unless ready arrives in it.
        else if (cnt_q == CNT_LAST) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      EXEC: begin
        ir_d = IR_HALT;
        if (!PCWre) begin
          state_d = HALT;
        end else begin
          pc_d    = PCSrc ? (pc4_q + (imm_ext << 2)) : pc4_q;
          pc4_d   = pc_d + 32'd4;
          state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      pc4_q   <= PC_INIT + 32'd4;
      ir_q    <= IR_HALT;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      ir_q    <= ir_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Request is gated by the raw reset so it drops in the same cycle reset is raised.
  assign ins_req   = (state_q == FETCH) && !Reset;
  assign ins_addr  = pc_q;
  assign ins_valid = (state_q == EXEC);
  assign halted    = (state_q == HALT);
  assign pc        = pc_q;
  assign pc_plus4  = pc4_q;
  assign op        = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm16     = ir_q[15:0];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
